// File: rtl/vram_write_buffer.sv
// rtl/vram_write_buffer.sv - captures CPU writes inside the video window and drains them to the framebuffer port
module vram_write_buffer #(
    parameter logic [15:0] VRAM_BASE = 16'hE000,
    parameter logic [16:0] VRAM_SIZE = 17'h1000,
    parameter int          DEPTH     = 8,
    parameter int          FB_AW     = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                bus_addr,
    input  logic [15:0]                bus_data,
    input  logic                       bus_write,
    output logic [FB_AW-1:0]           fb_addr,
    output logic [15:0]                fb_data,
    output logic                       fb_we,
    input  logic                       fb_ready,
    input  logic                       clr_ovf,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       full,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);

    logic             wr_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [FB_AW-1:0] addr_mem [DEPTH];
    logic [15:0]      data_mem [DEPTH];

    logic [16:0]      addr_ext;
    logic [16:0]      win_lo;
    logic [16:0]      win_hi;
    logic             in_window;
    logic [FB_AW-1:0] win_offset;
    logic             push_req;
    logic             pop;
    logic             push;
    logic             drop;

    // 17-bit compare so a window ending exactly at 64K still works
    assign addr_ext   = {1'b0, bus_addr};
    assign win_lo     = {1'b0, VRAM_BASE};
    assign win_hi     = win_lo + VRAM_SIZE;
    assign in_window  = (addr_ext >= win_lo) && (addr_ext < win_hi);
    assign win_offset = bus_addr[FB_AW-1:0] - VRAM_BASE[FB_AW-1:0];

    assign push_req = bus_write & ~wr_q & in_window;
    assign fb_we    = (fifo_count != '0);
    assign full     = (fifo_count == (PW+1)'(DEPTH));
    assign pop      = fb_we & fb_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign fb_addr  = fb_we ? addr_mem[rd_ptr] : '0;
    assign fb_data  = fb_we ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_q <= bus_write;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= win_offset;
            data_mem[wr_ptr] <= bus_data;
        end
    end

endmodule

// File: tb/tb_vram_write_buffer.sv
// tb/tb_vram_write_buffer.sv - self-checking bench for vram_write_buffer
module tb_vram_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_addr;
    logic [15:0] bus_data;
    logic        bus_write;
    logic [11:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        clr_ovf;
    logic [3:0]  fifo_count;
    logic        full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    vram_write_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_write  (bus_write),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .clr_ovf    (clr_ovf),
        .fifo_count (fifo_count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries queued when a qualifying edge is driven, popped on handshake
    typedef struct packed { logic [11:0] addr; logic [15:0] data; } ent_t;
    ent_t        exp_q[$];
    int          mcount = 0;
    logic        movf = 1'b0;
    logic        prev_w = 1'b0;
    logic        mon_en = 1'b0;
    logic [15:0] last_data = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic pop, edge_w, inwin, push_req;
            chk("mon_count", 32'(fifo_count), 32'(mcount));
            chk("mon_we", 32'(fb_we), 32'(mcount != 0));
            chk("mon_full", 32'(full), 32'(mcount == 8));
            chk("mon_ovf", 32'(overflow), 32'(movf));
            if (rst) begin
                exp_q.delete();
                mcount = 0;
                movf   = 1'b0;
                prev_w = 1'b0;
            end else begin
                pop      = (mcount != 0) && fb_ready;
                edge_w   = bus_write && !prev_w;
                inwin    = (bus_addr >= 16'hE000) && (bus_addr <= 16'hEFFF);
                push_req = edge_w && inwin;
                if (pop) begin
                    chk("head_addr", 32'(fb_addr), 32'(exp_q[0].addr));
                    chk("head_data", 32'(fb_data), 32'(exp_q[0].data));
                    last_data = fb_data;
                    void'(exp_q.pop_front());
                    mcount--;
                end
                if (push_req) begin
                    if (mcount < 8) begin
                        exp_q.push_back({bus_addr[11:0] - 12'h000, bus_data});
                        mcount++;
                    end else begin
                        movf = 1'b1;
                    end
                end
                if (!(push_req && !(mcount < 8)) && clr_ovf)
                    movf = 1'b0;
                prev_w = bus_write;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_write(input logic [15:0] a, input logic [15:0] d);
        step();
        bus_addr  = a;
        bus_data  = d;
        bus_write = 1'b1;
        step();
        bus_write = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int i;
        for (i = 0; i < 40 && fifo_count != 0; i++)
            @(negedge clk);
        chk(name, 32'(fifo_count), 32'd0);
        chk({name, "_q"}, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          len;
        logic        exp_we;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'hE005, 16'h1234, 3, 1'b1, 12'h005};
        vecs[1] = '{16'hDFFF, 16'hAAAA, 1, 1'b0, 12'h000};
        vecs[2] = '{16'hF000, 16'hBBBB, 2, 1'b0, 12'h000};
        vecs[3] = '{16'hEFFF, 16'hCCCC, 1, 1'b1, 12'hFFF};
        vecs[4] = '{16'hE000, 16'h0001, 1, 1'b1, 12'h000};
        vecs[5] = '{16'hE800, 16'h5A5A, 4, 1'b1, 12'h800};

        rst = 1'b1; bus_addr = '0; bus_data = '0; bus_write = 1'b0;
        fb_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single writes through the window test, ready held high
        fb_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            step();
            bus_addr  = vecs[v].addr;
            bus_data  = vecs[v].data;
            bus_write = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("vec_we", 32'(fb_we), 32'(vecs[v].exp_we));
            if (vecs[v].exp_we) begin
                chk("vec_addr", 32'(fb_addr), 32'(vecs[v].exp_addr));
                chk("vec_data", 32'(fb_data), 32'(vecs[v].data));
            end
            for (int k = 1; k < vecs[v].len; k++)
                step();
            step();
            bus_write = 1'b0;
            step();
            step();
        end
        wait_empty("vec_drain");

        // Nine writes with ready low: eight held, one dropped
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            pulse_write(16'hE100 + 16'(i), 16'h3000 + 16'(i));
        @(negedge clk);
        chk("ovf_count", 32'(fifo_count), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        step();
        fb_ready = 1'b1;
        wait_empty("ovf_drain");
        chk("ovf_last", 32'(last_data), 32'h3007);

        // Full with simultaneous pop and push
        step(); clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        fb_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            pulse_write(16'hE200 + 16'(i), 16'h4000 + 16'(i));
        step();
        fb_ready  = 1'b1;
        bus_addr  = 16'hE0AA;
        bus_data  = 16'hBEEF;
        bus_write = 1'b1;
        step();
        fb_ready  = 1'b0;
        bus_write = 1'b0;
        @(negedge clk);
        chk("pp_count", 32'(fifo_count), 32'd8);
        chk("pp_ovf", 32'(overflow), 32'd0);
        step();
        fb_ready = 1'b1;
        wait_empty("pp_drain");
        chk("pp_last", 32'(last_data), 32'hBEEF);

        // Reset with entries pending
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            pulse_write(16'hE300 + 16'(i), 16'h5000 + 16'(i));
        step();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst5_we", 32'(fb_we), 32'd0);
        chk("rst5_count", 32'(fifo_count), 32'd0);
        step();
        rst = 1'b0;
        pulse_write(16'hE123, 16'h7777);
        fb_ready = 1'b1;
        @(negedge clk);
        chk("rst5_addr", 32'(fb_addr), 32'h123);
        chk("rst5_data", 32'(fb_data), 32'h7777);
        wait_empty("rst5_drain");

        // Overflow clear and set/clear priority
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            pulse_write(16'hE400 + 16'(i), 16'h6000 + 16'(i));
        @(negedge clk);
        chk("clr_pre", 32'(overflow), 32'd1);
        step(); clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        @(negedge clk);
        chk("clr_alone", 32'(overflow), 32'd0);
        step();
        clr_ovf   = 1'b1;
        bus_addr  = 16'hE4FF;
        bus_data  = 16'h9999;
        bus_write = 1'b1;
        step();
        clr_ovf   = 1'b0;
        bus_write = 1'b0;
        @(negedge clk);
        chk("clr_vs_set", 32'(overflow), 32'd1);
        step();
        fb_ready = 1'b1;
        wait_empty("clr_drain");

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
